// File: rtl/opb_register_bank.sv
// OPB slave exposing NUM_REGS 32-bit registers in one address window.
// Each register is a writable control word or a read-only status word captured from the fabric.
module opb_register_bank #(
  parameter logic [31:0]          C_BASEADDR   = 32'h01010800,
  parameter logic [31:0]          C_HIGHADDR   = 32'h010108FF,
  parameter int                   C_OPB_AWIDTH = 32,
  parameter int                   C_OPB_DWIDTH = 32,
  parameter                       C_FAMILY     = "virtex6",
  parameter int                   NUM_REGS     = 4,
  parameter logic [NUM_REGS-1:0]  RO_MASK      = {NUM_REGS{1'b0}},
  parameter logic [31:0]          RST_VAL      = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  output logic [NUM_REGS*32-1:0]    user_data_out,
  input  logic [NUM_REGS*32-1:0]    user_data_in,
  output logic [NUM_REGS-1:0]       user_wr_stb
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  localparam logic [29:0] NUM_REGS_W = 30'(NUM_REGS);

  state_t              state;
  state_t              next_state;
  logic [31:0]         addr;
  logic [31:0]         offset;
  logic [29:0]         word_idx;
  logic [31:0]         wr_data;
  logic [3:0]          be;
  logic                hit;
  logic                in_range;
  logic                start;
  logic [NUM_REGS-1:0] sel;
  logic [31:0]         rd_data;
  logic [31:0]         regs [NUM_REGS];
  logic                unused_ok;

  // Big-endian bus numbering: bus bit n lands on user bit 31-n, so BE[0] enables user byte 3.
  assign addr     = OPB_ABus;
  assign wr_data  = OPB_DBus;
  assign be       = OPB_BE;
  assign offset   = addr - C_BASEADDR;
  assign word_idx = offset[31:2];
  assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign in_range = word_idx < NUM_REGS_W;
  assign start    = (state == IDLE) && hit;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = in_range && (word_idx == 30'(i));
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hit) next_state = ACK;
      ACK:     next_state = WAIT;
      WAIT:    if (!OPB_select) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read-only entries of regs hold the status shadow captured at the decode edge.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RO_MASK[i] ? 32'h0 : RST_VAL;
      end
      user_wr_stb <= '0;
      rd_data     <= '0;
    end else begin
      user_wr_stb <= '0;
      if (start) begin
        rd_data <= '0;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (start && sel[i]) begin
          if (RO_MASK[i]) begin
            if (OPB_RNW) begin
              regs[i] <= user_data_in[32*i +: 32];
              rd_data <= user_data_in[32*i +: 32];
            end
          end else if (OPB_RNW) begin
            rd_data <= regs[i];
          end else begin
            for (int b = 0; b < 4; b++) begin
              if (be[b]) begin
                regs[i][8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
            user_wr_stb[i] <= |be;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      user_data_out[32*i +: 32] = regs[i];
    end
  end

  assign Sl_xferAck = (state == ACK) && !OPB_Rst;
  assign Sl_DBus    = Sl_xferAck ? rd_data : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, offset[1:0], user_data_in, C_FAMILY};

endmodule

// File: tb/tb_opb_register_bank.sv
// Scoreboard bench for opb_register_bank: a bus master pushes expected read data,
// a monitor pops and compares on every Sl_xferAck.
module tb_opb_register_bank;

  logic         OPB_Clk = 1'b0;
  logic         OPB_Rst;
  logic [0:31]  OPB_ABus;
  logic [0:3]   OPB_BE;
  logic [0:31]  OPB_DBus;
  logic         OPB_RNW;
  logic         OPB_select;
  logic         OPB_seqAddr;
  logic [0:31]  Sl_DBus;
  logic         Sl_errAck;
  logic         Sl_retry;
  logic         Sl_toutSup;
  logic         Sl_xferAck;
  logic [127:0] user_data_out;
  logic [127:0] user_data_in;
  logic [3:0]   user_wr_stb;

  logic [31:0]  ro_val = 32'h10203040;
  logic [31:0]  exp_q [$];
  int           total = 0;
  int           bad = 0;

  logic         got_ack;
  int           ack_lat;
  int           extra_acks;
  logic [3:0]   stb_at_ack;
  logic [127:0] udo_at_ack;
  logic [3:0]   stb_after;
  logic [31:0]  dbus_after;
  logic [31:0]  ro_expected;

  opb_register_bank #(
    .NUM_REGS (4),
    .RO_MASK  (4'b0100),
    .RST_VAL  (32'h00000000)
  ) dut (
    .OPB_Clk       (OPB_Clk),
    .OPB_Rst       (OPB_Rst),
    .OPB_ABus      (OPB_ABus),
    .OPB_BE        (OPB_BE),
    .OPB_DBus      (OPB_DBus),
    .OPB_RNW       (OPB_RNW),
    .OPB_select    (OPB_select),
    .OPB_seqAddr   (OPB_seqAddr),
    .Sl_DBus       (Sl_DBus),
    .Sl_errAck     (Sl_errAck),
    .Sl_retry      (Sl_retry),
    .Sl_toutSup    (Sl_toutSup),
    .Sl_xferAck    (Sl_xferAck),
    .user_data_out (user_data_out),
    .user_data_in  (user_data_in),
    .user_wr_stb   (user_wr_stb)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  // Status word for register 2 changes every cycle, away from the sampling edge.
  always @(negedge OPB_Clk) ro_val <= ro_val + 32'h01010101;
  assign user_data_in = {32'hCAFE0003, ro_val, 32'hCAFE0001, 32'hCAFE0000};

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge OPB_Clk) begin
    if (Sl_xferAck === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected ack: got ack with data %h expected no ack", Sl_DBus);
      end else begin
        checkOutput("ack read data", 128'(Sl_DBus), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic rnw, input logic [31:0] data,
                               input logic [3:0] be, input bit expect_ack, input bit ro_read,
                               input logic [31:0] exp_rdata, input int hold);
    got_ack    = 1'b0;
    ack_lat    = -1;
    extra_acks = 0;
    @(posedge OPB_Clk) #1;
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_DBus   = data;
    OPB_BE     = be;
    OPB_select = 1'b1;
    @(posedge OPB_Clk);
    if (expect_ack) begin
      ro_expected = ro_val;
      exp_q.push_back(!rnw ? 32'h0 : (ro_read ? ro_val : exp_rdata));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck === 1'b1) begin
        got_ack    = 1'b1;
        ack_lat    = k;
        stb_at_ack = user_wr_stb;
        udo_at_ack = user_data_out;
        break;
      end
    end
    if (expect_ack) begin
      checkOutput("ack seen", 128'(got_ack), 128'(1));
      checkOutput("ack latency", 128'(ack_lat), 128'(0));
      if (!got_ack) void'(exp_q.pop_front());
    end else begin
      checkOutput("miss no ack", 128'(got_ack), 128'(0));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck === 1'b1) extra_acks++;
    end
    @(posedge OPB_Clk) #1;
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    stb_after  = user_wr_stb;
    dbus_after = Sl_DBus;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    OPB_Rst     = 1'b1;
    OPB_ABus    = '0;
    OPB_BE      = '0;
    OPB_DBus    = '0;
    OPB_RNW     = 1'b0;
    OPB_select  = 1'b0;
    OPB_seqAddr = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    checkOutput("reset user_data_out", user_data_out, 128'h0);
    checkOutput("reset xferAck", 128'(Sl_xferAck), 128'h0);
    checkOutput("reset DBus", 128'(Sl_DBus), 128'h0);
    checkOutput("reset wr_stb", 128'(user_wr_stb), 128'h0);
    OPB_Rst = 1'b0;

    $display("[TB] full word write to register 1");
    applyStimulus(32'h01010804, 1'b0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    checkOutput("reg1 value at ack", 128'(udo_at_ack[63:32]), 128'hDEADBEEF);
    checkOutput("strobe at ack", 128'(stb_at_ack), 128'b0010);
    checkOutput("strobe one cycle", 128'(stb_after), 128'h0);
    checkOutput("DBus zero after ack", 128'(dbus_after), 128'h0);

    $display("[TB] byte-enable partial write to register 0");
    applyStimulus(32'h01010800, 1'b0, 32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    applyStimulus(32'h01010800, 1'b0, 32'hAABBCCDD, 4'b1001, 1'b1, 1'b0, 32'h0, 0);
    checkOutput("reg0 partial write", 128'(udo_at_ack[31:0]), 128'hAA2233DD);
    checkOutput("reg0 partial strobe", 128'(stb_at_ack), 128'b0001);
    applyStimulus(32'h01010800, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0, 32'hAA2233DD, 0);

    $display("[TB] write with no byte enables");
    applyStimulus(32'h01010800, 1'b0, 32'h55555555, 4'h0, 1'b1, 1'b0, 32'h0, 0);
    checkOutput("BE=0 no strobe", 128'(stb_at_ack), 128'h0);
    checkOutput("BE=0 reg0 held", 128'(udo_at_ack[31:0]), 128'hAA2233DD);

    $display("[TB] readback of register 1 with low address bits set");
    applyStimulus(32'h01010807, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 0);

    $display("[TB] read-only status register");
    applyStimulus(32'h01010808, 1'b1, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 0);
    applyStimulus(32'h01010808, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    checkOutput("RO write no strobe", 128'(stb_at_ack), 128'h0);
    checkOutput("RO write reg0/reg1 held", 128'(udo_at_ack[63:0]), 128'hDEADBEEF_AA2233DD);

    $display("[TB] in-window index beyond NUM_REGS");
    applyStimulus(32'h01010820, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    applyStimulus(32'h01010820, 1'b0, 32'h77777777, 4'hF, 1'b1, 1'b0, 32'h0, 0);
    checkOutput("high index write no strobe", 128'(stb_at_ack), 128'h0);
    checkOutput("high index write regs held", 128'(udo_at_ack[63:0]), 128'hDEADBEEF_AA2233DD);

    $display("[TB] accesses outside the window");
    applyStimulus(32'h01010900, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 0);
    applyStimulus(32'h010107FC, 1'b0, 32'h12121212, 4'hF, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("miss DBus zero", 128'(dbus_after), 128'h0);
    checkOutput("miss regs held", user_data_out[63:0], 128'hDEADBEEF_AA2233DD);

    $display("[TB] select held high for several cycles");
    applyStimulus(32'h01010804, 1'b1, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF, 2);
    checkOutput("single ack per select", 128'(extra_acks), 128'h0);

    $display("[TB] reset during the ACK cycle");
    @(posedge OPB_Clk) #1;
    OPB_ABus   = 32'h01010804;
    OPB_RNW    = 1'b0;
    OPB_DBus   = 32'h12345678;
    OPB_BE     = 4'hF;
    OPB_select = 1'b1;
    @(posedge OPB_Clk);
    exp_q.push_back(32'h0);
    @(negedge OPB_Clk);
    checkOutput("pre-reset ack", 128'(Sl_xferAck), 128'h1);
    #1 OPB_Rst = 1'b1;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    checkOutput("reset aborts ack", 128'(Sl_xferAck), 128'h0);
    checkOutput("reset restores regs", user_data_out, 128'h0);
    checkOutput("reset clears strobe", 128'(user_wr_stb), 128'h0);
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    checkOutput("no ack in reset", 128'(Sl_xferAck), 128'h0);
    #1 OPB_Rst = 1'b0;
    @(posedge OPB_Clk);
    exp_q.push_back(32'h0);
    @(negedge OPB_Clk);
    checkOutput("new transfer after reset", 128'(Sl_xferAck), 128'h1);
    checkOutput("post-reset write", 128'(user_data_out[63:32]), 128'h12345678);
    @(posedge OPB_Clk) #1;
    OPB_select = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);

    checkOutput("scoreboard drained", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
